tpu_mat_seq: RTL

Parametrised matrix-transfer sequencer for the TPU compute array. It loads A (M×K) and B (K×N) from memory with programmable base addresses and row strides, and streams them to the array. It then triggers the compute, waits for completion under a watchdog, and writes C (M×N) back. It replaces the fixed-address, single-handshake loader with real request/grant/rvalid memory handshaking, backpressure, abort and error reporting.

---
 rtl/tpu_seq_pkg.sv | 16 +
 rtl/tpu_mat_seq_if.sv | 45 ++++
 rtl/tpu_mat_seq_addr_gen.sv | 52 +++++
 rtl/tpu_mat_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_seq_pkg.sv
// Shared types for the matrix-transfer sequencer: top-level states, per-word
// load phases and error codes.
package tpu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_COMPUTE, S_STORE, S_DRAIN, S_ERROR, S_DONE
  } seq_state_e;

  typedef enum logic [1:0] {PH_REQ, PH_WAIT, PH_PUSH} ld_phase_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_ZERO_DIM = 2'd1;
  localparam logic [1:0] ERR_ABORT    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

endpackage

// File: rtl/tpu_mat_seq_if.sv
// Memory bus, operand stream, compute trigger and result stream between the
// sequencer (master) and memory / compute array (slave).
interface tpu_mat_seq_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  ld_valid;
  logic                  ld_ready;
  logic                  ld_sel;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  cmp_start;
  logic                  cmp_done;
  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_WIDTH-1:0] res_data;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output ld_valid, ld_sel, ld_data,
    input  ld_ready,
    output cmp_start,
    input  cmp_done,
    input  res_valid, res_data,
    output res_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  ld_valid, ld_sel, ld_data,
    output ld_ready,
    input  cmp_start,
    output cmp_done,
    output res_valid, res_data,
    input  res_ready
  );
endinterface

// File: rtl/tpu_mat_seq_addr_gen.sv
// Row-major address walker: base + r*stride + c*WORD_BYTES, with the row start
// accumulated by stride addition. init has priority over step.
module tpu_addr_gen #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DIM_WIDTH    = 8,
  parameter int STRIDE_WIDTH = 16,
  parameter int WORD_BYTES   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   base,
  input  logic [STRIDE_WIDTH-1:0] stride,
  input  logic [DIM_WIDTH-1:0]    rows,
  input  logic [DIM_WIDTH-1:0]    cols,
  input  logic                    init,
  input  logic                    step,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic                    last
);
  logic [DIM_WIDTH-1:0]  row_cnt, col_cnt;
  logic [ADDR_WIDTH-1:0] row_start, addr_q, next_row;
  logic                  row_end;

  assign row_end  = (col_cnt == cols - DIM_WIDTH'(1));
  assign last     = row_end && (row_cnt == rows - DIM_WIDTH'(1));
  assign next_row = row_start + ADDR_WIDTH'(stride);
  assign addr     = addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt   <= '0;
      col_cnt   <= '0;
      row_start <= '0;
      addr_q    <= '0;
    end else if (init) begin
      row_cnt   <= '0;
      col_cnt   <= '0;
      row_start <= base;
      addr_q    <= base;
    end else if (step) begin
      if (row_end) begin
        col_cnt   <= '0;
        row_cnt   <= row_cnt + DIM_WIDTH'(1);
        row_start <= next_row;
        addr_q    <= next_row;
      end else begin
        col_cnt   <= col_cnt + DIM_WIDTH'(1);
        addr_q    <= addr_q + ADDR_WIDTH'(WORD_BYTES);
      end
    end
  end
endmodule

// File: rtl/tpu_mat_seq.sv
// Matrix-transfer sequencer: loads A then B into the array, runs the compute
// under a watchdog and stores C, with abort and sticky error reporting.
module tpu_mat_seq
  import tpu_seq_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DIM_WIDTH    = 8,
  parameter int STRIDE_WIDTH = 16,
  parameter int TIMEOUT      = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_WIDTH-1:0]   cfg_base_a,
  input  logic [ADDR_WIDTH-1:0]   cfg_base_b,
  input  logic [ADDR_WIDTH-1:0]   cfg_base_c,
  input  logic [STRIDE_WIDTH-1:0] cfg_stride_a,
  input  logic [STRIDE_WIDTH-1:0] cfg_stride_b,
  input  logic [STRIDE_WIDTH-1:0] cfg_stride_c,
  input  logic [DIM_WIDTH-1:0]    cfg_m,
  input  logic [DIM_WIDTH-1:0]    cfg_n,
  input  logic [DIM_WIDTH-1:0]    cfg_k,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [1:0]              err_code,
  output logic [31:0]             cycle_count,
  output logic [31:0]             word_count,
  tpu_mat_seq_if.master           bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  seq_state_e state, state_n;
  ld_phase_e  phase, phase_n;

  logic [DATA_WIDTH-1:0]   hold;
  logic [TW-1:0]           tmo_cnt;
  logic [DIM_WIDTH-1:0]    m_q, n_q, k_q;
  logic [ADDR_WIDTH-1:0]   base_b_q, base_c_q;
  logic [STRIDE_WIDTH-1:0] stride_a_q, stride_b_q, stride_c_q;

  logic mem_req, mem_we, ld_valid, res_ready, cmp_start;
  logic gen_init, gen_step, gen_last, hold_en, word_inc, err_set, clr_job, accept;
  logic [1:0]              err_n;
  logic [ADDR_WIDTH-1:0]   gen_base, gen_addr;
  logic [STRIDE_WIDTH-1:0] gen_stride;
  logic [DIM_WIDTH-1:0]    gen_rows, gen_cols;

  // The single walker is re-armed with the next matrix's base on the cycle
  // the previous one finishes, so the base mux looks one matrix ahead.
  assign gen_base   = (state == S_IDLE)   ? cfg_base_a :
                      (state == S_LOAD_A) ? base_b_q : base_c_q;
  assign gen_stride = (state == S_LOAD_A) ? stride_a_q :
                      (state == S_LOAD_B) ? stride_b_q : stride_c_q;
  assign gen_rows   = (state == S_LOAD_B) ? k_q : m_q;
  assign gen_cols   = (state == S_LOAD_A) ? k_q : n_q;

  tpu_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH), .DIM_WIDTH(DIM_WIDTH),
    .STRIDE_WIDTH(STRIDE_WIDTH), .WORD_BYTES(DATA_WIDTH / 8)
  ) u_agen (
    .clk(clk), .rst(rst), .base(gen_base), .stride(gen_stride),
    .rows(gen_rows), .cols(gen_cols), .init(gen_init), .step(gen_step),
    .addr(gen_addr), .last(gen_last)
  );

  assign accept = (state == S_IDLE) && start;

  always_comb begin
    state_n   = state;
    phase_n   = phase;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ld_valid  = 1'b0;
    res_ready = 1'b0;
    cmp_start = 1'b0;
    gen_init  = 1'b0;
    gen_step  = 1'b0;
    hold_en   = 1'b0;
    word_inc  = 1'b0;
    err_set   = 1'b0;
    err_n     = ERR_NONE;
    clr_job   = 1'b0;
    unique case (state)
      S_IDLE: if (start) begin
        if (cfg_m == '0 || cfg_n == '0 || cfg_k == '0) begin
          state_n = S_ERROR;
          err_set = 1'b1;
          err_n   = ERR_ZERO_DIM;
        end else begin
          clr_job  = 1'b1;
          gen_init = 1'b1;
          phase_n  = PH_REQ;
          state_n  = S_LOAD_A;
        end
      end
      S_LOAD_A, S_LOAD_B: begin
        if (abort) begin
          // A granted read must still return before the bus is free again.
          if (phase == PH_WAIT && !bus.mem_rvalid) state_n = S_DRAIN;
          else begin
            state_n = S_ERROR;
            err_set = 1'b1;
            err_n   = ERR_ABORT;
          end
        end else begin
          unique case (phase)
            PH_REQ: begin
              mem_req = 1'b1;
              if (bus.mem_gnt) phase_n = PH_WAIT;
            end
            PH_WAIT: if (bus.mem_rvalid) begin
              hold_en = 1'b1;
              phase_n = PH_PUSH;
            end
            PH_PUSH: begin
              ld_valid = 1'b1;
              if (bus.ld_ready) begin
                word_inc = 1'b1;
                gen_step = 1'b1;
                phase_n  = PH_REQ;
                if (gen_last) begin
                  gen_init = 1'b1;
                  state_n  = (state == S_LOAD_A) ? S_LOAD_B : S_COMPUTE;
                end
              end
            end
            default: phase_n = PH_REQ;
          endcase
        end
      end
      S_COMPUTE: begin
        if (abort) begin
          state_n = S_ERROR;
          err_set = 1'b1;
          err_n   = ERR_ABORT;
        end else begin
          cmp_start = (tmo_cnt == '0);
          if (bus.cmp_done) state_n = S_STORE;
          else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            state_n = S_ERROR;
            err_set = 1'b1;
            err_n   = ERR_TIMEOUT;
          end
        end
      end
      S_STORE: begin
        if (abort) begin
          state_n = S_ERROR;
          err_set = 1'b1;
          err_n   = ERR_ABORT;
        end else begin
          mem_req   = bus.res_valid;
          mem_we    = 1'b1;
          res_ready = bus.mem_gnt;
          if (bus.res_valid && bus.mem_gnt) begin
            word_inc = 1'b1;
            gen_step = 1'b1;
            if (gen_last) state_n = S_DONE;
          end
        end
      end
      S_DRAIN: if (bus.mem_rvalid) begin
        state_n = S_ERROR;
        err_set = 1'b1;
        err_n   = ERR_ABORT;
      end
      S_ERROR: state_n = S_IDLE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      phase       <= PH_REQ;
      hold        <= '0;
      tmo_cnt     <= '0;
      error       <= 1'b0;
      err_code    <= ERR_NONE;
      cycle_count <= '0;
      word_count  <= '0;
      m_q         <= '0;
      n_q         <= '0;
      k_q         <= '0;
      base_b_q    <= '0;
      base_c_q    <= '0;
      stride_a_q  <= '0;
      stride_b_q  <= '0;
      stride_c_q  <= '0;
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      tmo_cnt <= (state == S_COMPUTE) ? tmo_cnt + TW'(1) : '0;
      if (hold_en) hold <= bus.mem_rdata;
      if (accept) begin
        m_q        <= cfg_m;
        n_q        <= cfg_n;
        k_q        <= cfg_k;
        base_b_q   <= cfg_base_b;
        base_c_q   <= cfg_base_c;
        stride_a_q <= cfg_stride_a;
        stride_b_q <= cfg_stride_b;
        stride_c_q <= cfg_stride_c;
      end
      if (clr_job) begin
        cycle_count <= '0;
        word_count  <= '0;
        error       <= 1'b0;
        err_code    <= ERR_NONE;
      end else begin
        if (state != S_IDLE) cycle_count <= cycle_count + 32'd1;
        if (word_inc)        word_count  <= word_count + 32'd1;
      end
      if (err_set) begin
        error    <= 1'b1;
        err_code <= err_n;
      end
    end
  end

  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = gen_addr;
  assign bus.mem_wdata = bus.res_data;
  assign bus.ld_valid  = ld_valid;
  assign bus.ld_sel    = (state == S_LOAD_B);
  assign bus.ld_data   = hold;
  assign bus.cmp_start = cmp_start;
  assign bus.res_ready = res_ready;
endmodule
